// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Row-scan sequencer for a 4x4 keypad behind the kb_db debounce datapath.
//   Walks an active-low row strobe. When a debounced key matches the current
//   row and exactly one column, it captures that key and decodes it to a
//   4-bit keycode, then waits for a release before it resumes scanning.
//   Keycodes are queued in a small show-ahead FIFO that has a valid/ready head.
//
// Optional feature (compile-time macro KEYPAD_REPEAT_EN):
//   While a key stays held in HOLD, the captured code is pushed again after
//   REPEAT_DELAY cycles and then every REPEAT_CYC cycles. If the macro is
//   undefined, the repeat timer and its parameters do not exist.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   scan_en_i      1 = rows advance, 0 = current row frozen
//   kb_valid_i     debounced key present
//   kb_row_i[3:0]  debounced row pattern, active-low
//   kb_col_i[3:0]  debounced column pattern, active-low
//   row_scan_o     registered row strobe, exactly one bit low
//   key_valid_o    FIFO head valid
//   key_code_o     FIFO head keycode (0 when empty)
//   key_ready_i    consumer pops the head when key_valid_o & key_ready_i
//   fifo_count_o   number of buffered events
//   overflow_o     sticky: an event was dropped because the FIFO was full
//   overflow_clr_i clears overflow_o (a drop in the same cycle wins)
//   busy_o         1 whenever the sequencer is not in SCAN
module keypad_scan_ctrl #(
  parameter int ROW_DWELL    = 131080,
  parameter int RELEASE_CYC  = 1024,
  parameter int DEPTH        = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 1 << 22,
  parameter int REPEAT_CYC   = 1 << 20
`endif
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       scan_en_i,
  input  logic                       kb_valid_i,
  input  logic [3:0]                 kb_row_i,
  input  logic [3:0]                 kb_col_i,
  output logic [3:0]                 row_scan_o,
  output logic                       key_valid_o,
  output logic [3:0]                 key_code_o,
  input  logic                       key_ready_i,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       overflow_o,
  input  logic                       overflow_clr_i,
  output logic                       busy_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DWW = $clog2(ROW_DWELL + 1);
  localparam int RWW = $clog2(RELEASE_CYC + 1);

  localparam logic [DWW-1:0] DWELL_LAST = DWW'(ROW_DWELL - 1);
  localparam logic [RWW-1:0] REL_LAST   = RWW'(RELEASE_CYC - 1);
  localparam logic [CW-1:0]  FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {S_SCAN, S_CAPTURE, S_HOLD} state_e;

  // Active-low one-cold strobe for row index r.
  function automatic logic [3:0] row_strobe(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Keypad legend: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: *(E) 0 #(F) D
  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e         state_q;
  logic [1:0]     row_idx_q;
  logic [3:0]     row_scan_q;
  logic [DWW-1:0] dwell_q;
  logic [RWW-1:0] rel_q;
  logic [1:0]     col_q;
  logic [3:0]     code_q;
  logic           busy_q;

  // Column decode: only a single low column is a usable key.
  logic       col_one;
  logic [1:0] col_idx;
  always_comb begin
    col_one = 1'b0;
    col_idx = 2'd0;
    case (kb_col_i)
      4'b1110: begin col_one = 1'b1; col_idx = 2'd0; end
      4'b1101: begin col_one = 1'b1; col_idx = 2'd1; end
      4'b1011: begin col_one = 1'b1; col_idx = 2'd2; end
      4'b0111: begin col_one = 1'b1; col_idx = 2'd3; end
      default: ;
    endcase
  end

  // The key must belong to the row that is being strobed. Otherwise it is a
  // ghost from a previous row or a multi-key chord.
  logic key_hit;
  assign key_hit = kb_valid_i && (kb_row_i == row_scan_q) && col_one;

  logic [3:0] cap_code;
  assign cap_code = decode(row_idx_q, col_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_SCAN;
      row_idx_q  <= 2'd0;
      row_scan_q <= 4'b1110;
      dwell_q    <= '0;
      rel_q      <= '0;
      col_q      <= 2'd0;
      code_q     <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (key_hit) begin
            col_q   <= col_idx;
            state_q <= S_CAPTURE;
            busy_q  <= 1'b1;
          end else if (scan_en_i && !kb_valid_i) begin
            // Any kb_valid (even a rejected pattern) parks the row so that
            // kb_db is not disturbed while it resolves.
            if (dwell_q == DWELL_LAST) begin
              dwell_q    <= '0;
              row_idx_q  <= row_idx_q + 2'd1;
              row_scan_q <= row_strobe(row_idx_q + 2'd1);
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          code_q  <= cap_code;
          rel_q   <= '0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (kb_valid_i) begin
            rel_q <= '0;
          end else if (rel_q == REL_LAST) begin
            // The release is complete. Move off the pressed row so that the
            // next scan does not re-read a bouncing key.
            rel_q      <= '0;
            dwell_q    <= '0;
            row_idx_q  <= row_idx_q + 2'd1;
            row_scan_q <= row_strobe(row_idx_q + 2'd1);
            state_q    <= S_SCAN;
            busy_q     <= 1'b0;
          end else begin
            rel_q <= rel_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_SCAN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
  logic rep_fire;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_CYC) ? REPEAT_DELAY : REPEAT_CYC;
  localparam int RPW  = $clog2(RMAX + 1);
  localparam logic [RPW-1:0] REP_FIRST_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] REP_NEXT_LAST  = RPW'(REPEAT_CYC - 1);

  logic [RPW-1:0] rep_q;
  logic           rep_first_q;   // still waiting for the first (longer) repeat

  assign rep_fire = (state_q == S_HOLD) && kb_valid_i &&
                    (rep_q == (rep_first_q ? REP_FIRST_LAST : REP_NEXT_LAST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else if (state_q != S_HOLD || !kb_valid_i) begin
      // A single release cycle restarts the whole repeat schedule.
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_fire) begin
      rep_q       <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_q <= rep_q + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic       empty, full, push, pop, wr_en, drop;
  logic [3:0] push_data;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign pop       = !empty && key_ready_i;
  assign push      = (state_q == S_CAPTURE) || rep_fire;
  assign push_data = (state_q == S_CAPTURE) ? cap_code : code_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
    ovf_d = ovf_q;
    if (drop)                ovf_d = 1'b1;
    else if (overflow_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign row_scan_o   = row_scan_q;
  assign busy_o       = busy_q;
  assign key_valid_o  = !empty;
  assign key_code_o   = empty ? 4'd0 : mem_q[rd_q];
  assign fifo_count_o = cnt_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_REP = 4;   // capture, +16, +24, +32 within a 40-cycle hold
`else
  localparam int EXP_REP = 1;
`endif

  logic       clk, rst_n, scan_en, kb_valid, key_ready, overflow_clr;
  logic [3:0] kb_row, kb_col, row_scan, key_code;
  logic       key_valid, overflow, busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  keypad_scan_ctrl #(
    .ROW_DWELL(8), .RELEASE_CYC(4), .DEPTH(4)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_DELAY(16), .REPEAT_CYC(8)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .kb_valid_i(kb_valid),
    .kb_row_i(kb_row), .kb_col_i(kb_col), .row_scan_o(row_scan),
    .key_valid_o(key_valid), .key_code_o(key_code), .key_ready_i(key_ready),
    .fifo_count_o(fifo_count), .overflow_o(overflow),
    .overflow_clr_i(overflow_clr), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] scan;     // row strobe to wait for before pressing
    logic [3:0] row;      // kb_row presented
    logic [3:0] col;      // kb_col presented
    logic       exp_vld;  // event expected
    logic [3:0] exp_code;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] pat);
    int n = 0;
    while (row_scan !== pat && n < 200) begin @(negedge clk); n++; end
    chk("wait_row", 32'(row_scan), 32'(pat));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("wait_idle", 32'(busy), 0);
  endtask

  task automatic press_on(input logic [3:0] r, input logic [3:0] c);
    kb_valid = 1'b1; kb_row = r; kb_col = c;
  endtask

  task automatic press_off();
    kb_valid = 1'b0; kb_row = 4'hF; kb_col = 4'hF;
  endtask

  task automatic tap(input logic [3:0] r, input logic [3:0] c);
    wait_row(r);
    press_on(r, c);
    tick(3);
    press_off();
    wait_idle();
  endtask

  task automatic pop_one(input string nm, input logic [3:0] exp);
    chk({nm, "_valid"}, 32'(key_valid), 1);
    chk({nm, "_code"}, 32'(key_code), 32'(exp));
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Keypad map, hand-written: row index r, column c -> legend.
    tbl[0]  = '{4'b1110, 4'b1110, 4'b1110, 1'b1, 4'h1};
    tbl[1]  = '{4'b1110, 4'b1110, 4'b1101, 1'b1, 4'h2};
    tbl[2]  = '{4'b1110, 4'b1110, 4'b1011, 1'b1, 4'h3};
    tbl[3]  = '{4'b1110, 4'b1110, 4'b0111, 1'b1, 4'hA};
    tbl[4]  = '{4'b1101, 4'b1101, 4'b1110, 1'b1, 4'h4};
    tbl[5]  = '{4'b1101, 4'b1101, 4'b1101, 1'b1, 4'h5};
    tbl[6]  = '{4'b1101, 4'b1101, 4'b1011, 1'b1, 4'h6};
    tbl[7]  = '{4'b1101, 4'b1101, 4'b0111, 1'b1, 4'hB};
    tbl[8]  = '{4'b1011, 4'b1011, 4'b1110, 1'b1, 4'h7};
    tbl[9]  = '{4'b1011, 4'b1011, 4'b1101, 1'b1, 4'h8};
    tbl[10] = '{4'b1011, 4'b1011, 4'b1011, 1'b1, 4'h9};
    tbl[11] = '{4'b1011, 4'b1011, 4'b0111, 1'b1, 4'hC};
    tbl[12] = '{4'b0111, 4'b0111, 4'b1110, 1'b1, 4'hE};
    tbl[13] = '{4'b0111, 4'b0111, 4'b1101, 1'b1, 4'h0};
    tbl[14] = '{4'b0111, 4'b0111, 4'b1011, 1'b1, 4'hF};
    tbl[15] = '{4'b0111, 4'b0111, 4'b0111, 1'b1, 4'hD};
    tbl[16] = '{4'b1101, 4'b1110, 4'b1110, 1'b0, 4'h0};  // row mismatch
    tbl[17] = '{4'b0111, 4'b0111, 4'b0000, 1'b0, 4'h0};  // all columns
    tbl[18] = '{4'b1011, 4'b1011, 4'b1111, 1'b0, 4'h0};  // no column

    rst_n = 1'b0; scan_en = 1'b1; key_ready = 1'b0; overflow_clr = 1'b0;
    press_off();
    tick(2);
    chk("rst_row_scan", 32'(row_scan), 32'b1110);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_code", 32'(key_code), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // 1: idle row walk, then freeze with scan_en=0
    tick(7);  chk("t1_row0_hold", 32'(row_scan), 32'b1110);
    tick(1);  chk("t1_row1", 32'(row_scan), 32'b1101);
    tick(24); chk("t1_wrap", 32'(row_scan), 32'b1110);
    scan_en = 1'b0;
    tick(20); chk("t1_frozen", 32'(row_scan), 32'b1110);
    scan_en = 1'b1;

    // 2: key '5' held 40 cycles, latency and release timing
    wait_row(4'b1101);
    press_on(4'b1101, 4'b1101);
    tick(1);
    chk("t2_busy_capture", 32'(busy), 1);
    chk("t2_kv_early", 32'(key_valid), 0);
    tick(1);
    chk("t2_kv_lat2", 32'(key_valid), 1);
    chk("t2_code", 32'(key_code), 5);
    tick(38);
    chk("t2_count_held", 32'(fifo_count), 32'(EXP_REP));
    press_off();
    tick(3);  chk("t2_busy_rel3", 32'(busy), 1);
    tick(1);  chk("t2_busy_rel4", 32'(busy), 0);
    chk("t2_next_row", 32'(row_scan), 32'b1011);
    for (int i = 0; i < EXP_REP; i++) pop_one("t2_pop", 4'h5);
    chk("t2_empty", 32'(fifo_count), 0);

    // 4: two-column chord on the strobed row is ignored and parks the row
    wait_row(4'b1110);
    press_on(4'b1110, 4'b1100);
    tick(10);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_row_held", 32'(row_scan), 32'b1110);
    chk("t4_count", 32'(fifo_count), 0);
    press_off();
    tick(1);

    // Table: full key map plus rejected patterns
    for (int i = 0; i < 19; i++) begin
      wait_row(tbl[i].scan);
      press_on(tbl[i].row, tbl[i].col);
      tick(3);
      if (tbl[i].exp_vld) begin
        chk("tbl_busy", 32'(busy), 1);
        chk("tbl_valid", 32'(key_valid), 1);
        chk("tbl_code", 32'(key_code), 32'(tbl[i].exp_code));
        press_off();
        wait_idle();
        key_ready = 1'b1; tick(1); key_ready = 1'b0;
        chk("tbl_popped", 32'(fifo_count), 0);
      end else begin
        chk("tbl_rej_busy", 32'(busy), 0);
        chk("tbl_rej_valid", 32'(key_valid), 0);
        chk("tbl_rej_row", 32'(row_scan), 32'(tbl[i].scan));
        press_off();
        tick(1);
      end
    end

    // 3: overflow with no consumer, then full+push+pop, then drain
    tap(4'b1110, 4'b1110);   // 1
    tap(4'b1110, 4'b1101);   // 2
    tap(4'b1110, 4'b1011);   // 3
    tap(4'b1110, 4'b0111);   // A
    tap(4'b0111, 4'b0111);   // D, dropped
    chk("t3_count_full", 32'(fifo_count), 4);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_head", 32'(key_code), 1);
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);
    pop_one("t3_pop1", 4'h1);
    tap(4'b1110, 4'b1110);   // refill to full with '1'
    chk("t3_refull", 32'(fifo_count), 4);
    wait_row(4'b1101);
    press_on(4'b1101, 4'b1110);   // '4' pushed while the head pops
    tick(1);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    chk("t3_pushpop_count", 32'(fifo_count), 4);
    chk("t3_pushpop_ovf", 32'(overflow), 0);
    press_off();
    wait_idle();
    pop_one("t3_d3", 4'h3);
    pop_one("t3_dA", 4'hA);
    pop_one("t3_d1", 4'h1);
    pop_one("t3_d4", 4'h4);
    chk("t3_drained", 32'(fifo_count), 0);

    // 5: reset while holding a key with two events queued
    tap(4'b1101, 4'b1101);   // 5
    wait_row(4'b1011);
    press_on(4'b1011, 4'b1011);   // 9, held
    tick(4);
    chk("t5_pre_busy", 32'(busy), 1);
    chk("t5_pre_count", 32'(fifo_count), 2);
    rst_n = 1'b0;
    tick(1);
    chk("t5_count", 32'(fifo_count), 0);
    chk("t5_kv", 32'(key_valid), 0);
    chk("t5_row", 32'(row_scan), 32'b1110);
    chk("t5_busy", 32'(busy), 0);
    press_off();
    rst_n = 1'b1;
    tick(2);
    chk("t5_post_kv", 32'(key_valid), 0);

    // 6: '#' held 40 cycles, auto-repeat when enabled
    wait_row(4'b0111);
    press_on(4'b0111, 4'b1011);
    tick(40);
    press_off();
    wait_idle();
    chk("t6_count", 32'(fifo_count), 32'(EXP_REP));
    for (int i = 0; i < EXP_REP; i++) pop_one("t6_pop", 4'hF);
    chk("t6_empty", 32'(key_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
